// File: rtl/secp256k1_pkg.sv
// Shared secp256k1 constants and the state encoding of the modular-inverse engine.
package secp256k1_pkg;

  localparam logic [255:0] SECP256K1_P =
    256'hFFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFE_FFFFFC2F;
  localparam logic [255:0] SECP256K1_N =
    256'hFFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFE_BAAEDCE6_AF48A03B_BFD25E8C_D0364141;

  typedef enum logic [1:0] {
    MI_IDLE,
    MI_CHECK,
    MI_CALC,
    MI_FINISH
  } mod_inv_state_t;

endpackage

// File: rtl/mod_inv_step.sv
// One combinational step of the binary extended Euclidean algorithm modulo an odd m.
// Holds the conditional-add halver and modular subtractor so other field units can reuse them.
module mod_inv_step #(
  parameter int WIDTH = 256
) (
  input  logic [WIDTH-1:0] m,
  input  logic [WIDTH-1:0] u,
  input  logic [WIDTH-1:0] v,
  input  logic [WIDTH-1:0] x1,
  input  logic [WIDTH-1:0] x2,
  output logic             last,
  output logic [WIDTH-1:0] u_next,
  output logic [WIDTH-1:0] v_next,
  output logic [WIDTH-1:0] x1_next,
  output logic [WIDTH-1:0] x2_next
);

  localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

  // x/2 mod m: odd x gets m added first; the extra bit keeps the carry of x+m.
  function automatic logic [WIDTH-1:0] halve_mod(input logic [WIDTH-1:0] x,
                                                 input logic [WIDTH-1:0] md);
    logic [WIDTH:0] sum;
    sum = x[0] ? ({1'b0, x} + {1'b0, md}) : {1'b0, x};
    return sum[WIDTH:1];
  endfunction

  // a-b mod m for a,b in [0,m); wrap-around of a+m-b is harmless since the result is below m.
  function automatic logic [WIDTH-1:0] sub_mod(input logic [WIDTH-1:0] a,
                                               input logic [WIDTH-1:0] b,
                                               input logic [WIDTH-1:0] md);
    return (a >= b) ? (a - b) : (a + md - b);
  endfunction

  assign last = (u == ONE) || (v == ONE);

  always_comb begin
    u_next  = u;
    v_next  = v;
    x1_next = x1;
    x2_next = x2;
    if (last) begin
      u_next = u;
    end else if (!u[0]) begin
      u_next  = u >> 1;
      x1_next = halve_mod(x1, m);
    end else if (!v[0]) begin
      v_next  = v >> 1;
      x2_next = halve_mod(x2, m);
    end else if (u >= v) begin
      u_next  = u - v;
      x1_next = sub_mod(x1, x2, m);
    end else begin
      v_next  = v - u;
      x2_next = sub_mod(x2, x1, m);
    end
  end

endmodule

// File: rtl/mod_inv_bin.sv
// Modular inverse a^-1 mod m (m = P_MOD or N_MOD) with a start/busy/done handshake and input checks.
// Defining MOD_INV_BIN_TIMEOUT_EN adds a CALC-cycle watchdog limited by MAX_ITER.
module mod_inv_bin
  import secp256k1_pkg::*;
#(
  parameter int               WIDTH    = 256,
  parameter logic [WIDTH-1:0] P_MOD    = SECP256K1_P[WIDTH-1:0],
  parameter logic [WIDTH-1:0] N_MOD    = SECP256K1_N[WIDTH-1:0],
  parameter int               MAX_ITER = 4 * WIDTH
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             start,
  input  logic             mod_sel,
  input  logic [WIDTH-1:0] input_num,
  output logic             busy,
  output logic             done,
  output logic             err,
  output logic [WIDTH-1:0] inverse
);

  localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

  mod_inv_state_t   state;
  logic [WIDTH-1:0] m, u, v, x1, x2;
  logic [WIDTH-1:0] u_next, v_next, x1_next, x2_next;
  logic [WIDTH-1:0] m_sel;
  logic             step_last;
  logic             accept;
  logic             expired;

  assign m_sel  = mod_sel ? N_MOD : P_MOD;
  // done is still high in the first IDLE cycle; a start there is deliberately dropped.
  assign accept = (state == MI_IDLE) && start && !done;

  mod_inv_step #(.WIDTH(WIDTH)) u_step (
    .m       (m),
    .u       (u),
    .v       (v),
    .x1      (x1),
    .x2      (x2),
    .last    (step_last),
    .u_next  (u_next),
    .v_next  (v_next),
    .x1_next (x1_next),
    .x2_next (x2_next)
  );

`ifdef MOD_INV_BIN_TIMEOUT_EN
  localparam int CNT_W = $clog2(MAX_ITER + 1);
  logic [CNT_W-1:0] iter_cnt;

  assign expired = (iter_cnt == CNT_W'(MAX_ITER));

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      iter_cnt <= '0;
    end else if (accept) begin
      iter_cnt <= '0;
    end else if (state == MI_CALC && !expired) begin
      iter_cnt <= iter_cnt + CNT_W'(1);
    end
  end
`else
  assign expired = 1'b0;
`endif

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state   <= MI_IDLE;
      busy    <= 1'b0;
      done    <= 1'b0;
      err     <= 1'b0;
      inverse <= '0;
      m       <= '0;
      u       <= '0;
      v       <= '0;
      x1      <= '0;
      x2      <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        MI_IDLE: begin
          if (accept) begin
            m     <= m_sel;
            u     <= input_num;
            v     <= m_sel;
            x1    <= ONE;
            x2    <= '0;
            busy  <= 1'b1;
            err   <= 1'b0;
            state <= MI_CHECK;
          end
        end
        MI_CHECK: begin
          if (u == '0 || u >= m) begin
            err   <= 1'b1;
            state <= MI_FINISH;
          end else begin
            state <= MI_CALC;
          end
        end
        MI_CALC: begin
          if (step_last) begin
            state <= MI_FINISH;
          end else if (expired) begin
            err   <= 1'b1;
            state <= MI_FINISH;
          end else begin
            u  <= u_next;
            v  <= v_next;
            x1 <= x1_next;
            x2 <= x2_next;
          end
        end
        MI_FINISH: begin
          inverse <= err ? '0 : ((u == ONE) ? x1 : x2);
          done    <= 1'b1;
          busy    <= 1'b0;
          state   <= MI_IDLE;
        end
        default: state <= MI_IDLE;
      endcase
    end
  end

endmodule

// File: doc/mod_inv_bin.md
Name: mod_inv_bin

Overview:
- Parametrised modular-inverse engine for the secp256k1 datapath, using the binary extended Euclidean algorithm.
- Computes x = a^-1 mod m with a one-cycle-per-step datapath. m is chosen at run time between the field prime (P_MOD) and the group order (N_MOD).
- Serves point arithmetic (affine conversion, mod P) and signature logic (s^-1, mod N).
- Adds input validation, an error flag and a clean start/busy/done handshake.

Parameters:
- WIDTH, 256, operand/modulus width in bits.
- P_MOD, 256'hFFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFE_FFFFFC2F, modulus when mod_sel=0. Must be an odd prime.
- N_MOD, 256'hFFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFE_BAAEDCE6_AF48A03B_BFD25E8C_D0364141, modulus when mod_sel=1. Must be an odd prime.
- MAX_ITER, 4*WIDTH, watchdog limit on CALC cycles (used only with the optional feature).

Ports:
- clk  in  1  clock, rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- start  in  1  request; accepted only when busy=0.
- mod_sel  in  1  0: P_MOD, 1: N_MOD; sampled on accept.
- input_num  in  WIDTH  operand a; sampled on accept.
- busy  out  1  high from the cycle after accept until done.
- done  out  1  one-cycle pulse; result/err valid.
- err  out  1  valid with done: a==0, a>=m, or watchdog expiry.
- inverse  out  WIDTH  result in [0,m); held until the next accept.

Behaviour:
- Reset (reset_n low, async): state=IDLE; busy=0, done=0, err=0, inverse=0; all working registers cleared.
- States: IDLE, CHECK, CALC, FINISH.
- IDLE: on start=1, latch a, m (per mod_sel); set u=a, v=m, x1=1, x2=0, busy=1; go to CHECK. Otherwise stay.
- CHECK (1 cycle): if u==0 or u>=m, set err=1 and go to FINISH with inverse=0. Otherwise go to CALC.
- CALC: exactly one step per cycle, by priority:
  - (1) if u==1 or v==1, go to FINISH.
  - (2) else if u even: u=u>>1; x1 = x1 even ? x1>>1 : (x1+m)>>1, with the sum computed at WIDTH+1 bits.
  - (3) else if v even: same operation on v, x2.
  - (4) else if u>=v: u=u-v; x1 = x1>=x2 ? x1-x2 : x1+m-x2.
  - (5) else: v=v-u; x2 = x2>=x1 ? x2-x1 : x2+m-x1.
- Invariant: x1, x2 stay in [0,m) at all times.
- FINISH (1 cycle): inverse = (u==1) ? x1 : x2, or 0 on error. Pulse done=1, drop busy, return to IDLE.
- done is high only in the cycle the FSM leaves FINISH. A start in that same cycle is not accepted; the next start is accepted from IDLE.
- start while busy=1 is ignored; no queueing.
- Latency: accept → done = CALC step count + 3 cycles. Worst case ≤ 2*WIDTH+3 for a prime m.
- a=1 takes the CALC early exit on its first cycle: inverse=1, latency 3.
- All state transitions are registered. The next-state/datapath combinational block is fully assigned with no latches, and only the sequential block updates registers.

Optional Feature:
- Macro: MOD_INV_BIN_TIMEOUT_EN.
- Defined: an iteration counter of clog2(MAX_ITER+1) bits clears on accept and increments each CALC cycle. On reaching MAX_ITER, the FSM goes to FINISH with err=1 and inverse=0.
- Not defined: no counter exists and err covers only input checks. Termination relies on m being prime.

Decomposition:
- Shared package secp256k1_pkg holds the SECP256K1_P and SECP256K1_N constants and the mod_inv state encoding.
- One sub-module, mod_inv_step: combinational, selects and computes the next {u, v, x1, x2} from the current values and m. It contains the conditional-add halver and the modular subtractor, and is reusable by future field units.

Test Plan:
- WIDTH=8, P_MOD=251, N_MOD=13; a=3, mod_sel=0 → done with inverse=84, err=0. Same a with mod_sel=1 → inverse=9.
- WIDTH=256 defaults; a=2, mod_sel=0 → inverse=0x7FFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFF_7FFFFE18. a=1 → inverse=1, done exactly 3 cycles after accept.
- a=0, and a=P_MOD with mod_sel=0 → err=1, inverse=0, done 2 cycles after accept.
- Pulse start repeatedly while busy with different operands → only the first is computed; exactly one done pulse.
- Assert reset_n low mid-CALC → outputs immediately 0 and FSM in IDLE. A fresh start after release gives the correct result.
- Random a in [1,m) for both moduli against a reference model: check a*inverse mod m == 1 and latency ≤ 2*WIDTH+3. With MOD_INV_BIN_TIMEOUT_EN defined and MAX_ITER=4, a=3 (WIDTH=8) → err=1.
